// File: rtl/fir_pkg.sv
// Shared definitions for the FIR control path: filter geometry, sequencer
// state encoding and the pipeline drain length.
package fir_pkg;

  localparam int TAPS         = 10;  // filter taps / coefficient words used
  localparam int DATA_W       = 3;   // signed input sample width
  localparam int ADDR_W       = 4;   // coefficient SRAM address width
  localparam int COEFF_W      = 16;  // coefficient word width (MAC side)
  localparam int DRAIN_CYCLES = 2;   // cycles for SRAM + multiplier stages to empty
  localparam int DRAIN_W      = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/fir_delay_line.sv
// TAPS x DATA_W sample shift register.
//   clk_i      : clock
//   rst_i      : asynchronous active-high clear of every tap
//   shift_en_i : shift sample_i into tap 0, older taps move up by one
//   sample_i   : new sample
//   rd_addr_i  : tap index to read (tap 0 is the newest sample)
//   rd_data_o  : combinational read data, zero for indices beyond the last tap
module fir_delay_line
  import fir_pkg::*;
#(
  parameter int TAPS_P   = fir_pkg::TAPS,
  parameter int DATA_W_P = fir_pkg::DATA_W,
  parameter int ADDR_W_P = fir_pkg::ADDR_W
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                shift_en_i,
  input  logic [DATA_W_P-1:0] sample_i,
  input  logic [ADDR_W_P-1:0] rd_addr_i,
  output logic [DATA_W_P-1:0] rd_data_o
);

  localparam logic [ADDR_W_P-1:0] LAST_ADDR = ADDR_W_P'(TAPS_P - 1);

  logic [DATA_W_P-1:0] tap_q [TAPS_P];

  // Shift register storage with asynchronous clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int j = 0; j < TAPS_P; j++) begin
        tap_q[j] <= '0;
      end
    end else if (shift_en_i) begin
      tap_q[0] <= sample_i;
      for (int j = 1; j < TAPS_P; j++) begin
        tap_q[j] <= tap_q[j-1];
      end
    end
  end

  // Indexed read port; out-of-range indices read as zero.
  always_comb begin
    rd_data_o = '0;
    if (rd_addr_i <= LAST_ADDR) begin
      rd_data_o = tap_q[rd_addr_i];
    end else begin
      rd_data_o = '0;
    end
  end

endmodule

// File: rtl/fir_tap_sequencer.sv
// FIR control stage: accepts one signed sample per handshake into the delay
// line, then walks every tap issuing coefficient SRAM reads, delay-tap values
// and MAC enables, and flags the cycle where the MAC holds the finished sum.
//   iClk12M    : clock
//   iRst       : asynchronous active-high reset
//   iInValid   : input sample strobe
//   iInSample  : signed input sample
//   oInReady   : sample can be accepted (IDLE only)
//   oCsn       : coefficient SRAM chip select, active-low
//   oAddr      : coefficient SRAM address
//   oDelay     : delay-tap value aligned with SRAM read data
//   oEnMul     : MAC multiply enable
//   oEnAddAcc  : MAC add/accumulate enable
//   oMacRsn    : MAC synchronous clear, active-low
//   oOutValid  : one-cycle pulse, MAC output holds the completed sum
module fir_tap_sequencer
  import fir_pkg::*;
#(
  parameter int TAPS   = fir_pkg::TAPS,
  parameter int DATA_W = fir_pkg::DATA_W,
  parameter int ADDR_W = fir_pkg::ADDR_W
) (
  input  logic              iClk12M,
  input  logic              iRst,
  input  logic              iInValid,
  input  logic [DATA_W-1:0] iInSample,
  output logic              oInReady,
  output logic              oCsn,
  output logic [ADDR_W-1:0] oAddr,
  output logic [DATA_W-1:0] oDelay,
  output logic              oEnMul,
  output logic              oEnAddAcc,
  output logic              oMacRsn,
  output logic              oOutValid
);

  localparam logic [ADDR_W-1:0]  LAST_ADDR  = ADDR_W'(TAPS - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

  state_t              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DRAIN_W-1:0]  drain_q;
  logic                in_ready_q;
  logic                csn_q;
  logic                en_mul_q;
  logic                en_add_q;
  logic [DATA_W-1:0]   delay_q;
  logic                mac_rsn_q;
  logic                out_valid_q;
  logic                shift_en_d;
  logic [DATA_W-1:0]   tap_rd;

  // Handshake: ready is registered, so the first IDLE cycle after reset
  // (ready still low) must not accept a sample.
  always_comb begin
    shift_en_d = 1'b0;
    if ((state_q == IDLE) && in_ready_q && iInValid) begin
      shift_en_d = 1'b1;
    end else begin
      shift_en_d = 1'b0;
    end
  end

  fir_delay_line #(
    .TAPS_P   (TAPS),
    .DATA_W_P (DATA_W),
    .ADDR_W_P (ADDR_W)
  ) u_delay_line (
    .clk_i      (iClk12M),
    .rst_i      (iRst),
    .shift_en_i (shift_en_d),
    .sample_i   (iInSample),
    .rd_addr_i  (addr_q),
    .rd_data_o  (tap_rd)
  );

  // Sequencer FSM, address counter and registered MAC-side outputs.
  always_ff @(posedge iClk12M or posedge iRst) begin
    if (iRst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      drain_q     <= '0;
      in_ready_q  <= 1'b0;
      csn_q       <= 1'b1;
      en_mul_q    <= 1'b0;
      en_add_q    <= 1'b0;
      delay_q     <= '0;
      mac_rsn_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      // Pipeline stages trailing the SRAM read: the tap value and multiply
      // enable line up with the read data one cycle after the address, the
      // accumulate enable follows the multiply register one cycle later.
      en_mul_q    <= ~csn_q;
      delay_q     <= csn_q ? '0 : tap_rd;
      en_add_q    <= en_mul_q;
      out_valid_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (shift_en_d) begin
            in_ready_q <= 1'b0;
            mac_rsn_q  <= 1'b0;
            state_q    <= CLEAR;
          end else begin
            in_ready_q <= 1'b1;
            mac_rsn_q  <= 1'b1;
          end
        end
        CLEAR: begin
          mac_rsn_q <= 1'b1;
          csn_q     <= 1'b0;
          addr_q    <= '0;
          state_q   <= RUN;
        end
        RUN: begin
          if (addr_q == LAST_ADDR) begin
            csn_q   <= 1'b1;
            drain_q <= '0;
            state_q <= DRAIN;
          end else begin
            addr_q <= addr_q + 1'b1;
          end
        end
        DRAIN: begin
          if (drain_q == DRAIN_LAST) begin
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            drain_q <= drain_q + 1'b1;
          end
        end
        DONE: begin
          in_ready_q <= 1'b1;
          state_q    <= IDLE;
        end
        default: begin
          csn_q      <= 1'b1;
          in_ready_q <= 1'b0;
          mac_rsn_q  <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign oInReady  = in_ready_q;
  assign oCsn      = csn_q;
  assign oAddr     = addr_q;
  assign oDelay    = delay_q;
  assign oEnMul    = en_mul_q;
  assign oEnAddAcc = en_add_q;
  assign oMacRsn   = mac_rsn_q;
  assign oOutValid = out_valid_q;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Self-checking bench for fir_tap_sequencer with a coefficient SRAM and
// saturating MAC attached; expected sums come from a plain tap-list model.
module tb_fir_tap_sequencer;

  localparam int TAPS   = 10;
  localparam int DATA_W = 3;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [DATA_W-1:0] in_sample;
  logic              oInReady, oCsn, oEnMul, oEnAddAcc, oMacRsn, oOutValid;
  logic [ADDR_W-1:0] oAddr;
  logic [DATA_W-1:0] oDelay;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  logic signed [15:0] coeff [TAPS];
  int                 ref_taps [TAPS];
  logic signed [15:0] sram_q;
  int                 mul_q, acc_q, mac_out;

  // per-transaction trace, indexed by cycle after acceptance (1..15)
  int tr_csn [17], tr_addr [17], tr_mul [17], tr_add [17], tr_dly [17], tr_ready [17];
  int t_valid_cyc, t_nvalid, t_mac;
  bit t_accepted;

  fir_tap_sequencer dut (
    .iClk12M   (clk),
    .iRst      (rst),
    .iInValid  (in_valid),
    .iInSample (in_sample),
    .oInReady  (oInReady),
    .oCsn      (oCsn),
    .oAddr     (oAddr),
    .oDelay    (oDelay),
    .oEnMul    (oEnMul),
    .oEnAddAcc (oEnAddAcc),
    .oMacRsn   (oMacRsn),
    .oOutValid (oOutValid)
  );

  always #5 clk = ~clk;

  function automatic int clamp16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Downstream stages: 1-cycle SRAM, multiply register, wide accumulator
  // whose visible output saturates to 16 bits.
  always @(posedge clk) begin
    if (!oCsn) sram_q <= coeff[oAddr];
    if (!oMacRsn) begin
      mul_q <= 0;
      acc_q <= 0;
    end else begin
      if (oEnMul) mul_q <= int'(sram_q) * int'($signed(oDelay));
      if (oEnAddAcc) acc_q <= acc_q + mul_q;
    end
  end
  always_comb mac_out = clamp16(acc_q);

  function automatic void ref_clear();
    for (int i = 0; i < TAPS; i++) ref_taps[i] = 0;
  endfunction

  function automatic void ref_push(input int s);
    for (int i = TAPS - 1; i > 0; i--) ref_taps[i] = ref_taps[i-1];
    ref_taps[0] = s;
  endfunction

  function automatic int ref_sum();
    int s = 0;
    for (int i = 0; i < TAPS; i++) s += int'(coeff[i]) * ref_taps[i];
    return clamp16(s);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Drive one handshake and record the 15 cycles that follow acceptance.
  task automatic send(input logic signed [DATA_W-1:0] s);
    t_accepted = 1'b0;
    in_valid   = 1'b1;
    in_sample  = s;
    for (int w = 0; w < 40 && !t_accepted; w++) begin
      if (oInReady) t_accepted = 1'b1;
      tick();
    end
    in_valid  = 1'b0;
    in_sample = DATA_W'($urandom);
    if (t_accepted) ref_push(int'(s));
    t_valid_cyc = 0;
    t_nvalid    = 0;
    t_mac       = 0;
    for (int c = 1; c <= 15; c++) begin
      tr_csn[c]   = int'(oCsn);
      tr_addr[c]  = int'(oAddr);
      tr_mul[c]   = int'(oEnMul);
      tr_add[c]   = int'(oEnAddAcc);
      tr_dly[c]   = int'($signed(oDelay));
      tr_ready[c] = int'(oInReady);
      if (oOutValid) begin
        t_nvalid++;
        if (t_valid_cyc == 0) begin
          t_valid_cyc = c;
          t_mac       = mac_out;
        end
      end
      if (c < 15) tick();
    end
    tr_mul[16] = 0;
    tr_add[16] = int'(oEnAddAcc);
  endtask

  task automatic test_reset();
    int csn_act;
    rst = 1'b0; in_valid = 1'b0; in_sample = '0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_total++;
    if ({oInReady, oCsn, oAddr, oDelay, oEnMul, oEnAddAcc, oOutValid, oMacRsn} !==
        {1'b0, 1'b1, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      $display("FAIL reset_values: rdy=%b csn=%b addr=%0d dly=%0d mul=%b add=%b val=%b rsn=%b required 0 1 0 0 0 0 0 0",
               oInReady, oCsn, oAddr, oDelay, oEnMul, oEnAddAcc, oOutValid, oMacRsn);
    end else n_pass++;
    ref_clear();
    @(negedge clk) rst = 1'b0;
    tick();
    n_total++;
    if ({oInReady, oMacRsn} !== 2'b11) $display("FAIL post_reset_ready: rdy,rsn=%b required 11", {oInReady, oMacRsn});
    else n_pass++;
    csn_act = 0;
    for (int i = 0; i < 6; i++) begin
      if (oCsn !== 1'b1 || oEnMul !== 1'b0) csn_act++;
      tick();
    end
    n_total++;
    if (csn_act !== 0) $display("FAIL idle_quiet: active cycles=%0d required 0", csn_act);
    else n_pass++;
  endtask

  task automatic test_impulse();
    for (int i = 0; i < TAPS; i++) coeff[i] = 16'(i + 1);
    for (int k = 0; k < TAPS; k++) begin
      send((k == 0) ? 3'sd1 : 3'sd0);
      n_total++;
      if (!t_accepted || t_valid_cyc !== 14 || t_nvalid !== 1) $display("FAIL impulse_timing[%0d]: acc=%0d valid_cyc=%0d pulses=%0d required 1 14 1", k, t_accepted, t_valid_cyc, t_nvalid);
      else n_pass++;
      n_total++;
      if (t_mac !== ref_sum() || t_mac !== k + 1) $display("FAIL impulse_sum[%0d]: got %0d required %0d", k, t_mac, k + 1);
      else n_pass++;
    end
    n_total++;
    if (tr_ready[15] !== 1) $display("FAIL ready_after_done: got %0d required 1", tr_ready[15]);
    else n_pass++;
  endtask

  task automatic test_alignment();
    int n_mul, n_add, first_mul, bad_pair, bad_dly;
    send(3'sd3);
    send(-3'sd4);
    n_mul = 0; n_add = 0; first_mul = 0; bad_pair = 0; bad_dly = 0;
    for (int c = 1; c <= 15; c++) begin
      if (tr_mul[c] == 1) begin
        if (first_mul == 0) first_mul = c;
        if (tr_add[c+1] != 1) bad_pair++;
        if (tr_dly[c] != ref_taps[n_mul] || tr_addr[c-1] != n_mul || tr_csn[c-1] != 0) bad_dly++;
        n_mul++;
      end
      if (tr_add[c] == 1 && tr_mul[c-1] != 1) bad_pair++;
      if (tr_add[c] == 1) n_add++;
      if (tr_mul[c] == 0 && tr_dly[c] != 0) bad_dly++;
    end
    n_total++;
    if (n_mul !== TAPS || n_add !== TAPS || first_mul !== 3) $display("FAIL align_counts: mul=%0d add=%0d first=%0d required 10 10 3", n_mul, n_add, first_mul);
    else n_pass++;
    n_total++;
    if (bad_pair !== 0) $display("FAIL align_add_trails_mul: bad=%0d required 0", bad_pair);
    else n_pass++;
    n_total++;
    if (bad_dly !== 0) $display("FAIL align_delay_addr: bad=%0d required 0", bad_dly);
    else n_pass++;
    n_total++;
    if (t_mac !== ref_sum()) $display("FAIL align_sum: got %0d required %0d", t_mac, ref_sum());
    else n_pass++;
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < TAPS; i++) coeff[i] = 16'($urandom_range(0, 400)) - 16'd200;
    for (int k = 0; k < 12; k++) begin
      send(DATA_W'($urandom));
      if (!t_accepted || t_valid_cyc != 14 || t_mac != ref_sum()) begin
        bad++;
        $display("FAIL random_sum[%0d]: got %0d at cycle %0d required %0d at 14", k, t_mac, t_valid_cyc, ref_sum());
      end
    end
    n_total++;
    if (bad == 0) n_pass++;
  endtask

  task automatic test_back_to_back();
    int n_acc = 0, last = -1, bad_gap = 0, bad_sum = 0, n_val = 0;
    bit acc_now;
    logic signed [DATA_W-1:0] s;
    for (int i = 0; i < TAPS; i++) coeff[i] = 16'($urandom_range(0, 60)) - 16'd30;
    in_valid = 1'b1;
    for (int k = 0; k < 62; k++) begin
      in_sample = DATA_W'($urandom);
      acc_now = oInReady;
      s = in_sample;
      tick();
      if (acc_now) begin
        ref_push(int'(s));
        if (last >= 0 && cyc - last != 15) bad_gap++;
        last = cyc;
        n_acc++;
      end
      if (oOutValid) begin
        n_val++;
        if (mac_out != ref_sum()) bad_sum++;
      end
    end
    in_valid = 1'b0;
    for (int w = 0; w < 20 && !oInReady; w++) tick();
    n_total++;
    if (n_acc !== 5 || bad_gap !== 0) $display("FAIL backpressure_rate: accepts=%0d bad_gaps=%0d required 5 0", n_acc, bad_gap);
    else n_pass++;
    n_total++;
    if (n_val !== 4 || bad_sum !== 0) $display("FAIL backpressure_sums: pulses=%0d bad=%0d required 4 0", n_val, bad_sum);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    int n_val = 0, bad_dly = 0, m = 0;
    for (int i = 0; i < TAPS; i++) coeff[i] = 16'(i + 1);
    send(3'sd1);
    send(-3'sd3);
    in_valid = 1'b1; in_sample = 3'd2;
    for (int w = 0; w < 20 && !oInReady; w++) tick();
    tick();
    in_valid = 1'b0;
    for (int w = 0; w < 20 && !found; w++) begin
      if (oAddr == 4'd5 && !oCsn) found = 1'b1;
      else tick();
    end
    n_total++;
    if (!found) $display("FAIL mid_reset_reach_addr5: got 0 required 1");
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++;
    if ({oOutValid, oCsn, oMacRsn, oEnMul} !== 4'b0100) $display("FAIL mid_reset_outputs: val,csn,rsn,mul=%b required 0100", {oOutValid, oCsn, oMacRsn, oEnMul});
    else n_pass++;
    ref_clear();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    for (int w = 0; w < 20; w++) begin
      if (oOutValid) n_val++;
      tick();
    end
    n_total++;
    if (n_val !== 0) $display("FAIL mid_reset_no_valid: pulses=%0d required 0", n_val);
    else n_pass++;
    send(3'sd2);
    for (int c = 1; c <= 15; c++) begin
      if (tr_mul[c] == 1) begin
        if (tr_dly[c] != ((m == 0) ? 2 : 0)) bad_dly++;
        m++;
      end
    end
    n_total++;
    if (t_mac !== 2 || ref_sum() !== 2 || bad_dly !== 0 || m !== TAPS) $display("FAIL mid_reset_cleared_taps: sum=%0d bad_taps=%0d required 2 0", t_mac, bad_dly);
    else n_pass++;
  endtask

  task automatic test_saturation();
    int bad_t = 0;
    for (int i = 0; i < TAPS; i++) coeff[i] = 16'sh7FFF;
    for (int k = 0; k < TAPS; k++) begin
      send(3'sd3);
      if (!t_accepted || t_valid_cyc != 14 || t_nvalid != 1) bad_t++;
    end
    n_total++;
    if (bad_t !== 0) $display("FAIL sat_timing: bad=%0d required 0", bad_t);
    else n_pass++;
    n_total++;
    if (t_mac !== 32767 || ref_sum() !== 32767) $display("FAIL sat_value: got %0h required 7fff", t_mac);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_alignment();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1);
  end

endmodule

// File: doc/fir_tap_sequencer.md
Name: fir_tap_sequencer

Overview:
Upstream control stage of the FIR datapath. It accepts one signed 3-bit input sample per handshake and shifts it into a TAPS-deep delay line. It then walks every tap, issuing coefficient SRAM reads, delay-tap values and the multiply / add-accumulate enables to the MAC stage, and flags when the MAC output holds the finished filter result.

Parameters:
TAPS, 10, number of filter taps and coefficient SRAM words used
DATA_W, 3, signed input sample width
ADDR_W, 4, coefficient SRAM address width; must satisfy 2**ADDR_W >= TAPS

Ports:
iClk12M  input  1  system clock; the only clock
iRst  input  1  reset, asynchronous, active-high
iInValid  input  1  input sample strobe
iInSample  input  DATA_W  signed input sample
oInReady  output  1  sequencer can accept a sample (high only in IDLE)
oCsn  output  1  coefficient SRAM chip select, active-low, read-only access
oAddr  output  ADDR_W  coefficient SRAM address
oDelay  output  DATA_W  signed delay-tap value aligned with the SRAM read data
oEnMul  output  1  MAC multiply enable
oEnAddAcc  output  1  MAC add/accumulate enable
oMacRsn  output  1  MAC synchronous clear, active-low
oOutValid  output  1  one-cycle pulse: the MAC output equals the completed FIR sum

Behaviour:
- Clock/reset: one clock, iClk12M. Reset iRst is asynchronous and active-high.
- Reset values:
  - oInReady=0, oCsn=1, oAddr=0, oDelay=0, oEnMul=0, oEnAddAcc=0, oOutValid=0, oMacRsn=0.
  - All delay taps are 0.
  - FSM is in IDLE.
  - On the first cycle after reset release: oMacRsn=1 and oInReady=1.
- All outputs are registered. SRAM read latency is 1 cycle: data for oAddr in cycle k is valid in cycle k+1.
- FSM states: IDLE -> CLEAR -> RUN -> DRAIN -> DONE -> IDLE.
  - IDLE: oInReady=1. When iInValid=1 at a clock edge, the sample is accepted: tap[j] <= tap[j-1] for j>=1, tap[0] <= iInSample. Next state is CLEAR.
  - CLEAR (1 cycle): oMacRsn=0, which clears the MAC accumulator and multiplier register.
  - RUN (TAPS cycles): oCsn=0, oAddr counts 0..TAPS-1, one step per cycle.
  - DRAIN (2 cycles): lets the pipeline empty.
  - DONE (1 cycle): oOutValid=1.
- Pipeline alignment:
  - If oAddr=i in cycle k, then in cycle k+1 oDelay=tap[i] (tap[0] is the newest sample) and oEnMul=1.
  - In cycle k+2, oEnAddAcc=1.
- Latency: with acceptance at edge E0, oOutValid is high in cycle TAPS+4 after E0 (cycle 14 for TAPS=10). The FSM is back in IDLE at cycle TAPS+5.
- Throughput: one sample per TAPS+5 cycles.
- iInValid while oInReady=0 is ignored. Upstream must hold the sample until the handshake completes.
- Outside their active windows: oCsn=1, oEnMul=0, oEnAddAcc=0, oDelay=0, oAddr holds its last value.
- Reset mid-operation:
  - Aborts immediately; no oOutValid is issued.
  - Delay line is cleared and oMacRsn is driven low.
  - The pending sample is lost.
- Arithmetic:
  - The sequencer performs no arithmetic on samples; oDelay is passed bit-exact.
  - Address counter width is ADDR_W and never exceeds TAPS-1; there is no wrap.
  - Saturation is handled downstream in the MAC stage.

Decomposition:
- Shared package fir_pkg holds:
  - constants TAPS, DATA_W, ADDR_W, COEFF_W=16;
  - the state enumeration {IDLE, CLEAR, RUN, DRAIN, DONE};
  - DRAIN_CYCLES=2.
- One sub-module: fir_delay_line (TAPS x DATA_W shift register with shift enable, async clear and indexed read port).
- The FSM and address counter stay in fir_tap_sequencer.

Test Plan:
1. Reset then idle:
   - Stimulus: assert iRst asynchronously mid-cycle, then release.
   - Required response: all outputs take their reset values at once; next cycle oInReady=1 and oMacRsn=1; no oCsn activity while iInValid=0.
2. Impulse response:
   - Stimulus: SRAM model coeff[i]=i+1. Send sample 1, then nine samples of 0, each with its own handshake.
   - Required response: the MAC output at each oOutValid is 1,2,...,10; oOutValid occurs 14 cycles after each acceptance.
3. Alignment check:
   - Stimulus: send samples 3 then -4.
   - Required response: during the second RUN, oDelay sequence is -4,3,0,0,... paired with addresses 0,1,2,...; oEnAddAcc trails oEnMul by exactly 1 cycle; exactly 10 pulses of each.
4. Backpressure:
   - Stimulus: hold iInValid=1 continuously with a changing iInSample.
   - Required response: accepts exactly one sample per 15 cycles, only when oInReady=1; samples presented during busy cycles are never shifted in.
5. Reset mid-RUN:
   - Stimulus: assert iRst at oAddr=5.
   - Required response: no oOutValid; after release, taps all read 0; a following sample of 2 with coeff[i]=i+1 gives a MAC output of 2.
6. Saturation passthrough:
   - Stimulus: all coefficients 16'h7FFF, ten samples of 3.
   - Required response: the MAC output at the final oOutValid is 16'h7FFF; sequencing timing is unchanged.
